keypad_entry_ctrl: RTL

Sequencing controller for the 10-key decimal keypad. It synchronises and debounces the raw one-hot key lines, and runs a press/release state machine so each physical press commits exactly one BCD digit. Committed digits accumulate in a NDIGITS-digit entry buffer. On an enter strobe the buffer is published as a number for downstream logic such as displays and comparators.

---
 rtl/keypad_entry_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns raw one-hot keypad lines into committed BCD digits.
// The raw key lines pass through a 2-flop synchroniser.
// A press/release FSM debounces each key so that one physical press commits one digit.
// Committed digits shift into an NDIGITS-deep entry buffer.
// An enter strobe publishes the buffer as a number.
//
// Handshake/strobe semantics: clr and ent are single-cycle synchronous strobes
// with no back-pressure. value_valid is a one-cycle qualifier and is high on
// exactly the cycle in which value holds a newly published number. When
// strobes and a commit land in the same cycle, the priority is:
// clr > ent (only when the buffer is non-empty) > digit commit.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NDIGITS         = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [9:0]                     key_t,
    input  logic                           clr,
    input  logic                           ent,
    output logic [4*NDIGITS-1:0]           digits,
    output logic [$clog2(NDIGITS+1)-1:0]   count,
    output logic [4*NDIGITS-1:0]           value,
    output logic                           value_valid,
    output logic                           ovf,
    output logic                           key_down,
    output logic [3:0]                     cur_code,
    output logic [1:0]                     dbg_state_o
);

    localparam int CW    = $clog2(NDIGITS + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]    COUNT_MAX = CW'(NDIGITS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DB_PRESS = 2'd1,
        S_HELD     = 2'd2,
        S_DB_REL   = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           cand_q;
    logic                 key_down_q;
    logic [3:0]           cur_code_q;

    logic [9:0]           sync1_q;
    logic [9:0]           sync2_q;
    logic [9:0]           ks;

    logic [4*NDIGITS-1:0] digits_q;
    logic [4*NDIGITS-1:0] digits_d;
    logic [CW-1:0]        count_q;
    logic [4*NDIGITS-1:0] value_q;
    logic                 value_valid_q;
    logic                 ovf_q;

    logic [3:0]           n_set;
    logic                 ks_onehot;
    logic [3:0]           ks_code;
    logic [9:0]           cand_mask;
    logic                 key_match;
    logic                 commit_w;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_t;
            sync2_q <= sync1_q;
        end
    end

    assign ks = sync2_q;

    // Population count and binary encode of the synchronised key vector.
    always_comb begin
        n_set   = 4'd0;
        ks_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n_set = n_set + 4'(ks[i]);
            if (ks[i]) begin
                ks_code = 4'(i);
            end
        end
        ks_onehot = (n_set == 4'd1);
    end

    assign cand_mask = 10'(1) << cand_q;
    assign key_match = (ks == cand_mask);

    // A digit commits on the last counting edge of a still-matching press.
    assign commit_w = (state_q == S_DB_PRESS) && key_match && (cnt_q == CNT_LAST);

    // Press/release FSM with its counter and registered key status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'd0;
            key_down_q <= 1'b0;
            cur_code_q <= 4'hF;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ks_onehot) begin
                        cand_q  <= ks_code;
                        cnt_q   <= '0;
                        state_q <= S_DB_PRESS;
                    end
                end
                S_DB_PRESS: begin
                    if (!key_match) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        cur_code_q <= cand_q;
                        key_down_q <= 1'b1;
                        state_q    <= S_HELD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_HELD: begin
                    // Extra keys while held are ignored; only a full release matters.
                    if (ks == 10'd0) begin
                        cnt_q   <= '0;
                        state_q <= S_DB_REL;
                    end
                end
                S_DB_REL: begin
                    if (ks != 10'd0) begin
                        state_q <= S_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        key_down_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer with the candidate digit shifted in at the low nibble.
    always_comb begin
        digits_d      = digits_q << 4;
        digits_d[3:0] = cand_q;
    end

    // Entry buffer, publish register and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q      <= '0;
            count_q       <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            if (clr) begin
                digits_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else if (ent && (count_q != '0)) begin
                value_q       <= digits_q;
                value_valid_q <= 1'b1;
                digits_q      <= '0;
                count_q       <= '0;
                ovf_q         <= 1'b0;
            end else if (commit_w) begin
                if (count_q < COUNT_MAX) begin
                    digits_q <= digits_d;
                    count_q  <= count_q + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign digits      = digits_q;
    assign count       = count_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign ovf         = ovf_q;
    assign key_down    = key_down_q;
    assign cur_code    = cur_code_q;
    assign dbg_state_o = state_q;

endmodule
